// File: rtl/hv_mem_loader.sv
// hv_mem_loader: streams hypervector rows from a host chunk interface into the
// IM, projm_pos and projm_neg memories of the fusion core.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 one-cycle load request, honoured only when idle
//   chunk_in/chunk_valid  host data chunk and its valid
//   chunk_ready           loader accepts a chunk (transfer = valid && ready)
//   write_enable          memory mode, 0 = host write mode, 1 = inference mode
//   write_enable_valid    one-cycle strobe telling the core to latch write_enable
//   *_addr / *_hvin       row address and row data for the three target memories
//   busy                  high whenever a load is in progress
//   done                  one-cycle pulse when a load completes
module hv_mem_loader #(
  parameter int unsigned sram_addr_width = 4,
  parameter int unsigned num_entries     = 4,
  parameter int unsigned hv_dimension    = 2000,
  parameter int unsigned chunk_width     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [chunk_width-1:0]     chunk_in,
  input  logic                       chunk_valid,
  output logic                       chunk_ready,
  output logic                       write_enable,
  output logic                       write_enable_valid,
  output logic [sram_addr_width-1:0] im_addr,
  output logic [sram_addr_width-1:0] projm_pos_addr,
  output logic [sram_addr_width-1:0] projm_neg_addr,
  output logic [hv_dimension-1:0]    im_hvin,
  output logic [hv_dimension-1:0]    projm_pos_hvin,
  output logic [hv_dimension-1:0]    projm_neg_hvin,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned chunks_per_hv = (hv_dimension + chunk_width - 1) / chunk_width;
  localparam int unsigned cnt_w         = (chunks_per_hv > 1) ? $clog2(chunks_per_hv) : 1;
  // All chunks but the last are buffered; the last one is taken straight from chunk_in.
  localparam int unsigned asm_w         = (chunks_per_hv - 1) * chunk_width;
  localparam int unsigned last_w        = hv_dimension - asm_w;

  localparam logic [cnt_w-1:0]           last_chunk = cnt_w'(chunks_per_hv - 1);
  localparam logic [sram_addr_width-1:0] last_row   = sram_addr_width'(num_entries - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_COLLECT,
    ST_WRITE,
    ST_SETTLE,
    ST_EXIT
  } state_e;

  typedef enum logic [1:0] {
    TG_IM,
    TG_POS,
    TG_NEG
  } target_e;

  state_e                     state_q, state_d;
  target_e                    target_q, target_d;
  logic [cnt_w-1:0]           chunk_cnt_q, chunk_cnt_d;
  logic [sram_addr_width-1:0] row_q, row_d;
  logic [asm_w-1:0]           asm_q, asm_d;
  logic [hv_dimension-1:0]    hv_full;
  logic                       xfer;

  logic                       chunk_ready_q, chunk_ready_d;
  logic                       we_q, we_d;
  logic                       wev_q, wev_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [sram_addr_width-1:0] im_addr_q, im_addr_d;
  logic [sram_addr_width-1:0] pos_addr_q, pos_addr_d;
  logic [sram_addr_width-1:0] neg_addr_q, neg_addr_d;
  logic [hv_dimension-1:0]    im_hv_q, im_hv_d;
  logic [hv_dimension-1:0]    pos_hv_q, pos_hv_d;
  logic [hv_dimension-1:0]    neg_hv_q, neg_hv_d;

  // chunk_ready_q is only ever high in COLLECT, so this is the only transfer qualifier
  assign xfer = chunk_valid && chunk_ready_q;

  // Assembly buffer: slice k captures chunk k, LSB-first
  for (genvar k = 0; k < int'(chunks_per_hv) - 1; k++) begin : g_asm
    assign asm_d[k*chunk_width +: chunk_width] =
      (xfer && (chunk_cnt_q == cnt_w'(k))) ? chunk_in : asm_q[k*chunk_width +: chunk_width];
  end

  // Complete row as seen on the final transfer; upper bits of the last chunk are dropped
  assign hv_full = {chunk_in[last_w-1:0], asm_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    chunk_cnt_d   = chunk_cnt_q;
    row_d         = row_q;
    im_addr_d     = im_addr_q;
    pos_addr_d    = pos_addr_q;
    neg_addr_d    = neg_addr_q;
    im_hv_d       = im_hv_q;
    pos_hv_d      = pos_hv_q;
    neg_hv_d      = neg_hv_q;
    we_d          = we_q;
    wev_d         = 1'b0;
    done_d        = 1'b0;
    chunk_ready_d = 1'b0;
    busy_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        target_d    = TG_IM;
        row_d       = '0;
        chunk_cnt_d = '0;
        state_d     = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (xfer) begin
          if (chunk_cnt_q == last_chunk) begin
            state_d = ST_WRITE;
            // Only the selected target moves; the others keep being re-written unchanged
            case (target_q)
              TG_IM: begin
                im_addr_d = row_q;
                im_hv_d   = hv_full;
              end
              TG_POS: begin
                pos_addr_d = row_q;
                pos_hv_d   = hv_full;
              end
              TG_NEG: begin
                neg_addr_d = row_q;
                neg_hv_d   = hv_full;
              end
              default: ;
            endcase
          end else begin
            chunk_cnt_d = chunk_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if ((target_q == TG_NEG) && (row_q == last_row)) begin
          state_d = ST_SETTLE;
        end else begin
          state_d     = ST_COLLECT;
          chunk_cnt_d = '0;
          if (row_q == last_row) begin
            row_d = '0;
            case (target_q)
              TG_IM:   target_d = TG_POS;
              TG_POS:  target_d = TG_NEG;
              default: target_d = target_q;
            endcase
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_SETTLE: state_d = ST_EXIT;
      ST_EXIT:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs describe the state being entered, so they are valid throughout it
    chunk_ready_d = (state_d == ST_COLLECT);
    busy_d        = (state_d != ST_IDLE);
    if (state_d == ST_ENTER) begin
      we_d  = 1'b0;
      wev_d = 1'b1;
    end else if (state_d == ST_EXIT) begin
      we_d   = 1'b1;
      wev_d  = 1'b1;
      done_d = 1'b1;
    end
  end

  // State and output registers; reset leaves the core strobed into inference mode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      target_q      <= TG_IM;
      chunk_cnt_q   <= '0;
      row_q         <= '0;
      asm_q         <= '0;
      chunk_ready_q <= 1'b0;
      we_q          <= 1'b1;
      wev_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      im_addr_q     <= '0;
      pos_addr_q    <= '0;
      neg_addr_q    <= '0;
      im_hv_q       <= '0;
      pos_hv_q      <= '0;
      neg_hv_q      <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      chunk_cnt_q   <= chunk_cnt_d;
      row_q         <= row_d;
      asm_q         <= asm_d;
      chunk_ready_q <= chunk_ready_d;
      we_q          <= we_d;
      wev_q         <= wev_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      im_addr_q     <= im_addr_d;
      pos_addr_q    <= pos_addr_d;
      neg_addr_q    <= neg_addr_d;
      im_hv_q       <= im_hv_d;
      pos_hv_q      <= pos_hv_d;
      neg_hv_q      <= neg_hv_d;
    end
  end

  assign chunk_ready        = chunk_ready_q;
  assign write_enable       = we_q;
  assign write_enable_valid = wev_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign im_addr            = im_addr_q;
  assign projm_pos_addr     = pos_addr_q;
  assign projm_neg_addr     = neg_addr_q;
  assign im_hvin            = im_hv_q;
  assign projm_pos_hvin     = pos_hv_q;
  assign projm_neg_hvin     = neg_hv_q;

endmodule

// File: doc/hv_mem_loader.md
HV_MEM_LOADER -- requirements
Module: hv_mem_loader

Interface
REQ-001 Parameter sram_addr_width, default 4: width of every address output.
REQ-002 Parameter num_entries, default 4: number of hypervector rows written per target memory (1..2^sram_addr_width).
REQ-003 Parameter hv_dimension, default 2000: hypervector width in bits.
REQ-004 Parameter chunk_width, default 32: host chunk width; chunks_per_hv = ceil(hv_dimension/chunk_width).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-009 chunk_in  in  chunk_width  host data chunk.
REQ-010 chunk_valid  in  1  chunk_in valid.
REQ-011 chunk_ready  out  1  loader accepts chunk; a transfer occurs when chunk_valid && chunk_ready.
REQ-012 write_enable  out  1  memory mode value, active low: 0 = host write mode, 1 = inference mode.
REQ-013 write_enable_valid  out  1  one-cycle strobe that makes the fusion core latch write_enable.
REQ-014 im_addr, projm_pos_addr, projm_neg_addr  out  sram_addr_width each  target row addresses.
REQ-015 im_hvin, projm_pos_hvin, projm_neg_hvin  out  hv_dimension each  target row data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on load completion.

Function
REQ-018 States: IDLE, ENTER, COLLECT, WRITE, SETTLE, EXIT; all outputs are registered.
REQ-019 IDLE: start=1 -> ENTER; otherwise stay; chunk_ready=0.
REQ-020 ENTER (1 cycle): write_enable=0, write_enable_valid=1; target=IM, row=0, chunk count=0 -> COLLECT.
REQ-021 COLLECT: chunk_ready=1; each transfer places chunk k at bits [k*chunk_width +: chunk_width] of the assembly register, LSB-first; bits at or above hv_dimension in the last chunk are discarded.
REQ-022 COLLECT -> WRITE on the transfer of chunk chunks_per_hv-1; chunk_valid low stalls with no state change.
REQ-023 WRITE (1 cycle): the selected target's addr and hvin are loaded together with row and assembled HV; chunk_ready=0.
REQ-024 Non-selected targets hold their addr/hvin unchanged; the core re-writes the same value every cycle in write mode, so holding is required.
REQ-025 Target order: IM rows 0..num_entries-1, then projm_pos rows 0..num_entries-1, then projm_neg rows 0..num_entries-1.
REQ-026 After WRITE: if not last row of projm_neg -> COLLECT with next row/target, chunk count=0; else -> SETTLE.
REQ-027 SETTLE (1 cycle): outputs held so the last row is written at least once more -> EXIT.
REQ-028 EXIT (1 cycle): write_enable=1, write_enable_valid=1, done=1 -> IDLE.
REQ-029 write_enable_valid is 0 in every state except ENTER and EXIT; write_enable holds its value between strobes.
REQ-030 start while busy is ignored; chunk_valid outside COLLECT is ignored and consumes no data.
REQ-031 Total accepted chunks per load = 3*num_entries*chunks_per_hv exactly.
REQ-032 Minimum load time with chunk_valid held high = 1 + 3*num_entries*(chunks_per_hv+1) + 2 cycles from the start sample to the done cycle.

Reset
REQ-033 Reset values: state IDLE, write_enable=1, write_enable_valid=1, chunk_ready=0, busy=0, done=0, all addr=0, all hvin=0, counters=0.
REQ-034 write_enable_valid returns to 0 on the first clock edge with rst low, so every reset returns the core to inference mode.
REQ-035 Reset mid-load abandons the load without completing the partial row; no done pulse is produced.

Verification
REQ-036 Defaults, chunk_valid high, start pulse -> ENTER strobe with write_enable=0; 63 chunks per row; 12 WRITE cycles; done exactly 2+12*64+1 cycles after start; write_enable=1 strobe with done.
REQ-037 Row data = chunk index k in every chunk -> im_hvin[63:32]=1, bits [1999:1984]=62; upper 16 bits of chunk 62 discarded.
REQ-038 Random chunk_valid gaps -> chunk_ready never high outside COLLECT; no chunk lost or duplicated (scoreboard against 756 sent).
REQ-039 During IM phase -> projm_pos/neg addr and hvin remain 0; after load all three addr outputs = 3.
REQ-040 rst asserted mid projm_pos row 1 -> next cycle all outputs at reset values with write_enable_valid=1, then 0; no done; a new start completes a full load.
REQ-041 start pulsed while busy, and chunk_valid high in IDLE -> no effect on sequence or chunk count.
